// File: rtl/csa_calc_dispatch_if.sv
// Handshake and engine-array bus for the CSA calc dispatcher.
// The slave side is the dispatcher. The master side is the front end together with the engine array.
interface csa_calc_dispatch_if #(
    parameter int IN_WIDTH  = 160,
    parameter int OUT_WIDTH = 224,
    parameter int NUM_LANES = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [IN_WIDTH-1:0]            in_data;

    logic [NUM_LANES-1:0]           eng_start;
    logic [IN_WIDTH-1:0]            eng_data;
    logic [NUM_LANES-1:0]           eng_done;
    logic [NUM_LANES*OUT_WIDTH-1:0] eng_result;

    logic                           out_valid;
    logic                           out_ready;
    logic [OUT_WIDTH-1:0]           out_data;

    modport slave (
        input  in_valid, in_data, eng_done, eng_result, out_ready,
        output in_ready, eng_start, eng_data, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, eng_done, eng_result, out_ready,
        input  in_ready, eng_start, eng_data, out_valid, out_data
    );
endinterface

// File: rtl/csa_calc_dispatch.sv
// Multi-lane CSA calc dispatcher.
// Records are buffered in an input FIFO and issued round-robin to external engines.
// Results are collected strictly in issue order into a first-word-fall-through output FIFO.
//
// lane state | meaning
// -----------+-------------------------------------------------------------
// LANE_IDLE  | lane free, may receive the next record
// LANE_PEND  | record issued, waiting for eng_done
// LANE_HOLD  | result latched, waiting for its turn at the collect pointer
// LANE_DROP  | flushed while pending; the late eng_done is swallowed
module csa_calc_dispatch #(
    parameter int IN_WIDTH  = 160,
    parameter int OUT_WIDTH = 224,
    parameter int NUM_LANES = 4,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    csa_calc_dispatch_if.slave        bus,
    output logic [$clog2(IN_DEPTH):0]  in_level,
    output logic [$clog2(OUT_DEPTH):0] out_level,
    output logic [CNT_WIDTH-1:0]      issued_cnt,
    output logic [CNT_WIDTH-1:0]      completed_cnt,
    output logic [1:0]                error_sticky
);

    localparam int IN_AW   = $clog2(IN_DEPTH);
    localparam int OUT_AW  = $clog2(OUT_DEPTH);
    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int BUSY_W  = $clog2(NUM_LANES + 1);

    localparam logic [IN_AW:0]     IN_ONE   = 1;
    localparam logic [OUT_AW:0]    OUT_ONE  = 1;
    localparam logic [LANE_W-1:0]  LANE_ONE = 1;
    localparam logic [LANE_W-1:0]  LANE_MAX = LANE_W'(NUM_LANES - 1);
    localparam logic [BUSY_W-1:0]  BUSY_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_PEND = 2'd1,
        LANE_HOLD = 2'd2,
        LANE_DROP = 2'd3
    } lane_state_e;

    lane_state_e lane_state_q [NUM_LANES];
    lane_state_e lane_state_d [NUM_LANES];
    logic [OUT_WIDTH-1:0] lane_res_q [NUM_LANES];
    logic [NUM_LANES-1:0] lane_latch;

    logic [IN_WIDTH-1:0]  in_mem [IN_DEPTH];
    logic [IN_AW:0]       in_wr_ptr_q, in_rd_ptr_q, in_count;
    logic                 in_full, in_empty, in_push, in_ovf;
    logic [IN_WIDTH-1:0]  in_head;

    logic [OUT_WIDTH-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW:0]      out_wr_ptr_q, out_rd_ptr_q, out_count;
    logic                 out_full, out_empty, out_push, out_pop;

    logic [LANE_W-1:0]    ip_q, cp_q;
    logic [BUSY_W-1:0]    busy_cnt;
    logic                 any_drop, reserve_ok, issue, collect, done_err;

    logic [NUM_LANES-1:0] eng_start_q;
    logic [IN_WIDTH-1:0]  eng_data_q;

    assign in_count  = in_wr_ptr_q - in_rd_ptr_q;
    assign in_full   = (in_count == (IN_AW + 1)'(IN_DEPTH));
    assign in_empty  = (in_count == '0);
    assign in_head   = in_mem[in_rd_ptr_q[IN_AW-1:0]];
    // in_ready is held low while reset is asserted, then reflects FIFO space.
    assign bus.in_ready = rst_n && !in_full;
    assign in_push   = bus.in_valid && bus.in_ready && !flush;
    assign in_ovf    = bus.in_valid && in_full && !flush;
    assign in_level  = in_count;

    assign out_count = out_wr_ptr_q - out_rd_ptr_q;
    assign out_full  = (out_count == (OUT_AW + 1)'(OUT_DEPTH));
    assign out_empty = (out_count == '0);
    assign out_level = out_count;
    assign bus.out_valid = !out_empty;
    assign bus.out_data  = out_mem[out_rd_ptr_q[OUT_AW-1:0]];
    assign out_pop   = bus.out_valid && bus.out_ready && !flush;

    // Lanes holding a reserved output slot, and whether any flushed lane is still outstanding.
    always_comb begin
        busy_cnt = '0;
        any_drop = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_state_q[i] == LANE_PEND || lane_state_q[i] == LANE_HOLD)
                busy_cnt = busy_cnt + BUSY_ONE;
            if (lane_state_q[i] == LANE_DROP)
                any_drop = 1'b1;
        end
    end

    // Every issued record owns an output slot, so the output FIFO can never overflow.
    assign reserve_ok = (32'(out_count) + 32'(busy_cnt)) < 32'(OUT_DEPTH);
    assign issue      = !in_empty && (lane_state_q[ip_q] == LANE_IDLE) && reserve_ok
                        && !any_drop && !flush;
    assign collect    = (lane_state_q[cp_q] == LANE_HOLD) && !flush;
    assign out_push   = collect && (!out_full || out_pop);

    // Per-lane next state, result latch enables and done-protocol error detection.
    always_comb begin
        done_err   = 1'b0;
        lane_latch = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_state_d[i] = lane_state_q[i];
            case (lane_state_q[i])
                LANE_IDLE: begin
                    if (bus.eng_done[i])
                        done_err = 1'b1;
                    if (issue && ip_q == LANE_W'(i))
                        lane_state_d[i] = LANE_PEND;
                end
                LANE_PEND: begin
                    if (flush)
                        lane_state_d[i] = bus.eng_done[i] ? LANE_IDLE : LANE_DROP;
                    else if (bus.eng_done[i]) begin
                        lane_state_d[i] = LANE_HOLD;
                        lane_latch[i]   = 1'b1;
                    end
                end
                LANE_HOLD: begin
                    if (bus.eng_done[i])
                        done_err = 1'b1;
                    if (flush || (collect && cp_q == LANE_W'(i)))
                        lane_state_d[i] = LANE_IDLE;
                end
                LANE_DROP: begin
                    if (bus.eng_done[i])
                        lane_state_d[i] = LANE_IDLE;
                end
                default: lane_state_d[i] = LANE_IDLE;
            endcase
        end
    end

    // Lane state, pointers, counters, FIFO pointers and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++)
                lane_state_q[i] <= LANE_IDLE;
            ip_q          <= '0;
            cp_q          <= '0;
            in_wr_ptr_q   <= '0;
            in_rd_ptr_q   <= '0;
            out_wr_ptr_q  <= '0;
            out_rd_ptr_q  <= '0;
            issued_cnt    <= '0;
            completed_cnt <= '0;
            error_sticky  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++)
                lane_state_q[i] <= lane_state_d[i];
            if (done_err)
                error_sticky[0] <= 1'b1;
            if (in_ovf)
                error_sticky[1] <= 1'b1;
            if (flush) begin
                ip_q          <= '0;
                cp_q          <= '0;
                in_wr_ptr_q   <= '0;
                in_rd_ptr_q   <= '0;
                out_wr_ptr_q  <= '0;
                out_rd_ptr_q  <= '0;
                issued_cnt    <= '0;
                completed_cnt <= '0;
            end else begin
                if (in_push)
                    in_wr_ptr_q <= in_wr_ptr_q + IN_ONE;
                if (issue) begin
                    in_rd_ptr_q <= in_rd_ptr_q + IN_ONE;
                    ip_q        <= (ip_q == LANE_MAX) ? '0 : ip_q + LANE_ONE;
                    issued_cnt  <= issued_cnt + CNT_ONE;
                end
                if (out_push) begin
                    out_wr_ptr_q  <= out_wr_ptr_q + OUT_ONE;
                    cp_q          <= (cp_q == LANE_MAX) ? '0 : cp_q + LANE_ONE;
                    completed_cnt <= completed_cnt + CNT_ONE;
                end
                if (out_pop)
                    out_rd_ptr_q <= out_rd_ptr_q + OUT_ONE;
            end
        end
    end

    // Registered start pulse and record towards the engine being started.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_start_q <= '0;
            eng_data_q  <= '0;
        end else begin
            eng_start_q <= issue ? (NUM_LANES'(1) << ip_q) : '0;
            if (issue)
                eng_data_q <= in_head;
        end
    end

    assign bus.eng_start = eng_start_q;
    assign bus.eng_data  = eng_data_q;

    // Capture each lane's result on its done pulse so the engine is free to be reused.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_latch[i])
                lane_res_q[i] <= bus.eng_result[i*OUT_WIDTH +: OUT_WIDTH];
    end

    // Input FIFO storage.
    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wr_ptr_q[IN_AW-1:0]] <= bus.in_data;
    end

    // Output FIFO storage, fed from the lane at the collect pointer.
    always_ff @(posedge clk) begin
        if (out_push)
            out_mem[out_wr_ptr_q[OUT_AW-1:0]] <= lane_res_q[cp_q];
    end

endmodule

// File: tb/tb_csa_calc_dispatch.sv
// Directed bench for csa_calc_dispatch: four behavioural engines with per-lane latency,
// a four-deep output FIFO to exercise slot reservation, and a sixteen-deep input FIFO.
module tb_csa_calc_dispatch;

    localparam int IW = 160;
    localparam int OW = 224;
    localparam int NL = 4;
    localparam int ID = 16;
    localparam int OD = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic [$clog2(ID):0] in_level;
    logic [$clog2(OD):0] out_level;
    logic [CW-1:0]       issued_cnt, completed_cnt;
    logic [1:0]          error_sticky;

    csa_calc_dispatch_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_LANES(NL)) bus ();

    csa_calc_dispatch #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_LANES(NL),
        .IN_DEPTH(ID), .OUT_DEPTH(OD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus),
        .in_level(in_level),
        .out_level(out_level),
        .issued_cnt(issued_cnt),
        .completed_cnt(completed_cnt),
        .error_sticky(error_sticky)
    );

    // Behavioural engines: done pulses lane_delay cycles after the start is seen.
    int              lane_delay [NL];
    int              eng_cnt [NL];
    logic [IW-1:0]   eng_cap [NL];
    logic [NL-1:0]   model_done = '0;
    logic [NL-1:0]   man_done = '0;

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!rst_n) begin
                eng_cnt[i]    <= 0;
                eng_cap[i]    <= '0;
                model_done[i] <= 1'b0;
            end else begin
                model_done[i] <= 1'b0;
                if (bus.eng_start[i]) begin
                    eng_cnt[i] <= lane_delay[i];
                    eng_cap[i] <= bus.eng_data;
                end else if (eng_cnt[i] > 0) begin
                    eng_cnt[i] <= eng_cnt[i] - 1;
                    if (eng_cnt[i] == 1)
                        model_done[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.eng_done = model_done | man_done;

    for (genvar g = 0; g < NL; g++) begin : g_eng
        assign bus.eng_result[g*OW +: OW] = {32'(g), 32'hC0DE_0000, eng_cap[g]};
    end

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] got [32];
    int got_n;

    function automatic logic [IW-1:0] mk_rec(input int tag);
        mk_rec = {5{32'(tag) ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [OW-1:0] exp_res(input int lane, input int tag);
        exp_res = {32'(lane), 32'hC0DE_0000, mk_rec(tag)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        man_done = '0;
        for (int i = 0; i < NL; i++) lane_delay[i] = 5;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Records every word visible with out_ready high; it is popped at the following edge.
    task automatic collect(input int max_n, input int max_cycles);
        got_n = 0;
        for (int c = 0; c < max_cycles && got_n < max_n; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                got[got_n] = bus.out_data;
                got_n++;
            end
            tick();
        end
    endtask

    task automatic push_seq(input int first_tag, input int n);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk_rec(first_tag + k);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NL; i++) lane_delay[i] = 5;
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.eng_start !== 4'b0000 || bus.eng_data !== '0) begin
            errors++; $display("FAIL reset_outputs: out_valid %b eng_start %b eng_data %h expected 0/0/0",
                               bus.out_valid, bus.eng_start, bus.eng_data);
        end
        checks++;
        if (in_level !== 0 || out_level !== 0 || issued_cnt !== 0 || completed_cnt !== 0 || error_sticky !== 2'b00) begin
            errors++; $display("FAIL reset_status: in_level %0d out_level %0d issued %0d completed %0d err %b expected all 0",
                               in_level, out_level, issued_cnt, completed_cnt, error_sticky);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = mk_rec(1);
        tick();
        checks++;
        if (bus.eng_start !== 4'b0000 || in_level !== 1) begin
            errors++; $display("FAIL single_write: eng_start %b in_level %0d expected 0000/1", bus.eng_start, in_level);
        end
        bus.in_data = mk_rec(2);
        tick();
        checks++;
        if (bus.eng_start !== 4'b0001 || bus.eng_data !== mk_rec(1)) begin
            errors++; $display("FAIL single_start_a: eng_start %b eng_data %h expected 0001/%h", bus.eng_start, bus.eng_data, mk_rec(1));
        end
        bus.in_data = mk_rec(3);
        tick();
        checks++;
        if (bus.eng_start !== 4'b0010 || bus.eng_data !== mk_rec(2)) begin
            errors++; $display("FAIL single_start_b: eng_start %b eng_data %h expected 0010/%h", bus.eng_start, bus.eng_data, mk_rec(2));
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.eng_start !== 4'b0100 || bus.eng_data !== mk_rec(3)) begin
            errors++; $display("FAIL single_start_c: eng_start %b eng_data %h expected 0100/%h", bus.eng_start, bus.eng_data, mk_rec(3));
        end
        collect(3, 60);
        checks++;
        if (got_n !== 3) begin errors++; $display("FAIL single_count: got %0d results expected 3", got_n); end
        for (int k = 0; k < got_n && k < 3; k++) begin
            checks++;
            if (got[k] !== exp_res(k, k + 1)) begin
                errors++; $display("FAIL single_result[%0d]: got %h expected %h", k, got[k], exp_res(k, k + 1));
            end
        end
    endtask

    task automatic test_order();
        apply_reset();
        lane_delay[0] = 12;
        lane_delay[1] = 8;
        lane_delay[2] = 14;
        lane_delay[3] = 3;
        push_seq(10, 4);
        collect(4, 80);
        checks++;
        if (got_n !== 4) begin errors++; $display("FAIL order_count: got %0d results expected 4", got_n); end
        for (int k = 0; k < got_n && k < 4; k++) begin
            checks++;
            if (got[k] !== exp_res(k, 10 + k)) begin
                errors++; $display("FAIL order_result[%0d]: got %h expected %h", k, got[k], exp_res(k, 10 + k));
            end
        end
        checks++;
        if (completed_cnt !== 4 || issued_cnt !== 4) begin
            errors++; $display("FAIL order_counters: completed %0d issued %0d expected 4/4", completed_cnt, issued_cnt);
        end
    endtask

    task automatic test_reservation();
        apply_reset();
        for (int i = 0; i < NL; i++) lane_delay[i] = 2;
        bus.out_ready = 1'b0;
        push_seq(20, 8);
        repeat (30) tick();
        checks++;
        if (issued_cnt !== 4 || in_level !== 4 || out_level !== 4 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL reserve_stall: issued %0d in_level %0d out_level %0d out_valid %b expected 4/4/4/1",
                               issued_cnt, in_level, out_level, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        collect(8, 200);
        checks++;
        if (got_n !== 8) begin errors++; $display("FAIL reserve_count: got %0d results expected 8", got_n); end
        for (int k = 0; k < got_n && k < 8; k++) begin
            checks++;
            if (got[k] !== exp_res(k % NL, 20 + k)) begin
                errors++; $display("FAIL reserve_result[%0d]: got %h expected %h", k, got[k], exp_res(k % NL, 20 + k));
            end
        end
        checks++;
        if (issued_cnt !== 8 || completed_cnt !== 8) begin
            errors++; $display("FAIL reserve_counters: issued %0d completed %0d expected 8/8", issued_cnt, completed_cnt);
        end
    endtask

    task automatic test_overflow();
        int wait_c;
        apply_reset();
        for (int i = 0; i < NL; i++) lane_delay[i] = 2;
        bus.out_ready = 1'b0;
        push_seq(100, 4);
        wait_c = 0;
        while (out_level != 4 && wait_c < 50) begin
            tick();
            wait_c++;
        end
        checks++;
        if (out_level !== 4) begin errors++; $display("FAIL ovf_prefill: out_level %0d expected 4", out_level); end
        push_seq(200, 16);
        checks++;
        if (in_level !== 16 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_full: in_level %0d in_ready %b expected 16/0", in_level, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = mk_rec(999);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (error_sticky !== 2'b10 || in_level !== 16) begin
            errors++; $display("FAIL ovf_error: error_sticky %b in_level %0d expected 10/16", error_sticky, in_level);
        end
        bus.out_ready = 1'b1;
        collect(21, 400);
        checks++;
        if (got_n !== 20) begin errors++; $display("FAIL ovf_count: got %0d results expected 20", got_n); end
        for (int k = 0; k < got_n && k < 20; k++) begin
            checks++;
            if (got[k] !== exp_res(k % NL, (k < 4) ? 100 + k : 196 + k)) begin
                errors++; $display("FAIL ovf_result[%0d]: got %h expected %h", k, got[k],
                                   exp_res(k % NL, (k < 4) ? 100 + k : 196 + k));
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        lane_delay[0] = 10;
        lane_delay[1] = 10;
        push_seq(40, 2);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (issued_cnt !== 0 || in_level !== 0 || completed_cnt !== 0) begin
            errors++; $display("FAIL flush_clear: issued %0d in_level %0d completed %0d expected 0/0/0",
                               issued_cnt, in_level, completed_cnt);
        end
        lane_delay[0] = 3;
        bus.in_valid = 1'b1;
        bus.in_data  = mk_rec(77);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.eng_start !== 4'b0000 || in_level !== 1) begin
            errors++; $display("FAIL flush_block: eng_start %b in_level %0d expected 0000/1", bus.eng_start, in_level);
        end
        collect(2, 60);
        checks++;
        if (got_n !== 1) begin errors++; $display("FAIL flush_count: got %0d results expected 1", got_n); end
        if (got_n >= 1) begin
            checks++;
            if (got[0] !== exp_res(0, 77)) begin
                errors++; $display("FAIL flush_result: got %h expected %h", got[0], exp_res(0, 77));
            end
        end
        checks++;
        if (issued_cnt !== 1 || completed_cnt !== 1 || error_sticky !== 2'b00) begin
            errors++; $display("FAIL flush_status: issued %0d completed %0d err %b expected 1/1/00",
                               issued_cnt, completed_cnt, error_sticky);
        end
    endtask

    task automatic test_errors_and_reset();
        apply_reset();
        man_done = 4'b0100;
        tick();
        man_done = '0;
        checks++;
        if (error_sticky !== 2'b01) begin errors++; $display("FAIL idle_done_error: got %b expected 01", error_sticky); end
        for (int i = 0; i < NL; i++) lane_delay[i] = 10;
        push_seq(50, 2);
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.eng_start !== 4'b0000 || bus.eng_data !== '0) begin
            errors++; $display("FAIL midrun_reset_bus: in_ready %b out_valid %b eng_start %b eng_data %h expected 0/0/0/0",
                               bus.in_ready, bus.out_valid, bus.eng_start, bus.eng_data);
        end
        checks++;
        if (in_level !== 0 || out_level !== 0 || issued_cnt !== 0 || completed_cnt !== 0 || error_sticky !== 2'b00) begin
            errors++; $display("FAIL midrun_reset_status: in_level %0d out_level %0d issued %0d completed %0d err %b expected all 0",
                               in_level, out_level, issued_cnt, completed_cnt, error_sticky);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrun_release: in_ready %b out_valid %b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_order();
        test_reservation();
        test_overflow();
        test_flush();
        test_errors_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
